// File: rtl/ow_temp_responder.sv
// DS18B20-style 1-Wire responder: reset/presence, Skip ROM, Convert T and
// Read Scratchpad with a bit-serial Dallas CRC-8 over the served bytes.
module ow_temp_responder #(
  parameter int RST_MIN    = 80,
  parameter int PRES_WAIT  = 4,
  parameter int PRES_LEN   = 60,
  parameter int SAMPLE_AT  = 8,
  parameter int READ0_HOLD = 30
) (
  input  logic        clk_in,
  input  logic        rst,
  inout  wire         dq,
  input  logic [15:0] temp_in,
  output logic        conv_pulse,
  output logic [7:0]  last_cmd,
  output logic        cmd_err,
  output logic        tx_active
);

  localparam logic [6:0] LOW_SAT    = 7'(RST_MIN);
  localparam logic [6:0] WAIT_END   = 7'(PRES_WAIT - 1);
  localparam logic [6:0] PRES_END   = 7'(PRES_LEN - 1);
  localparam logic [3:0] SAMPLE_C   = 4'(SAMPLE_AT);
  localparam logic [4:0] HOLD_LOAD  = 5'(READ0_HOLD - 1);
  // The reset rise is acted on two edges after the bus actually released.
  localparam logic [6:0] WAIT_START = 7'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_PRES_WAIT, S_PRES, S_RX_ROM, S_RX_FUNC, S_TX
  } state_t;

  state_t      state, state_next;
  logic        dq_s, dq_d, fall, rise, rst_det;
  logic [6:0]  low_cnt, cnt;
  logic        pres_drv;
  logic        rx_state, slot_busy, sample, byte_done;
  logic [3:0]  slot_cnt;
  logic [7:0]  rx_shift, rx_byte;
  logic [2:0]  rx_bits;
  logic [6:0]  bit_idx;
  logic [7:0]  crc, crc_step, tx_byte;
  logic        tx_bit, tx_fall;
  logic [4:0]  hold_cnt;
  logic [15:0] sp_temp;

  assign fall      = dq_d & ~dq_s;
  assign rise      = dq_s & ~dq_d;
  assign rst_det   = rise && (low_cnt == LOW_SAT);
  assign rx_state  = (state == S_RX_ROM) || (state == S_RX_FUNC);
  assign sample    = rx_state && slot_busy && (slot_cnt == SAMPLE_C);
  assign rx_byte   = {dq_s, rx_shift[7:1]};
  assign byte_done = sample && (rx_bits == 3'd7);
  assign tx_fall   = (state == S_TX) && fall;
  assign tx_active = (state == S_TX);

  // Read-0 pulls the line combinationally on the detected fall so the master
  // sees it low within two edges; hold_cnt then stretches it.
  assign dq = (pres_drv || (tx_fall && !tx_bit) || (hold_cnt != 5'd0)) ? 1'b0 : 1'bz;

  always_comb begin
    tx_byte = sp_temp[7:0];
    case (bit_idx[5:3])
      3'd0: tx_byte = sp_temp[7:0];
      3'd1: tx_byte = sp_temp[15:8];
      3'd2: tx_byte = 8'h4B;
      3'd3: tx_byte = 8'h46;
      3'd4: tx_byte = 8'h7F;
      3'd5: tx_byte = 8'hFF;
      3'd6: tx_byte = 8'h0C;
      default: tx_byte = 8'h10;
    endcase
  end

  // Bits 64..71 come straight out of the CRC register as it shifts.
  assign tx_bit   = bit_idx[6] ? crc[0] : tx_byte[bit_idx[2:0]];
  assign crc_step = {1'b0, crc[7:1]} ^ ((crc[0] ^ tx_bit) ? 8'h8C : 8'h00);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_PRES_WAIT: if (cnt == WAIT_END) state_next = S_PRES;
      S_PRES:      if (cnt == PRES_END) state_next = S_RX_ROM;
      S_RX_ROM:    if (byte_done) state_next = (rx_byte == 8'hCC) ? S_RX_FUNC : S_IDLE;
      S_RX_FUNC:   if (byte_done) state_next = (rx_byte == 8'hBE) ? S_TX : S_IDLE;
      S_TX:        if (tx_fall && (bit_idx == 7'd71)) state_next = S_IDLE;
      default:     state_next = state;
    endcase
    if (rst_det) state_next = S_PRES_WAIT;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      dq_s       <= 1'b1;
      dq_d       <= 1'b1;
      low_cnt    <= 7'd0;
      cnt        <= 7'd0;
      pres_drv   <= 1'b0;
      slot_busy  <= 1'b0;
      slot_cnt   <= 4'd0;
      rx_shift   <= 8'h00;
      rx_bits    <= 3'd0;
      bit_idx    <= 7'd0;
      crc        <= 8'h00;
      hold_cnt   <= 5'd0;
      sp_temp    <= 16'h0550;
      conv_pulse <= 1'b0;
      last_cmd   <= 8'h00;
      cmd_err    <= 1'b0;
    end else begin
      dq_s       <= dq;
      dq_d       <= dq_s;
      conv_pulse <= 1'b0;
      pres_drv   <= (state_next == S_PRES);

      if (dq_s)                    low_cnt <= 7'd0;
      else if (low_cnt != LOW_SAT) low_cnt <= low_cnt + 7'd1;

      if (rst_det)                 cnt <= WAIT_START;
      else if (state_next != state) cnt <= 7'd0;
      else if ((state == S_PRES_WAIT) || (state == S_PRES)) cnt <= cnt + 7'd1;

      if (rst_det || !rx_state) begin
        slot_busy <= 1'b0;
        slot_cnt  <= 4'd0;
        rx_bits   <= 3'd0;
      end else if (sample) begin
        slot_busy <= 1'b0;
        rx_shift  <= rx_byte;
        rx_bits   <= rx_bits + 3'd1;
      end else if (slot_busy) begin
        slot_cnt  <= slot_cnt + 4'd1;
      end else if (fall) begin
        slot_busy <= 1'b1;
        slot_cnt  <= 4'd1;
      end

      if (rst_det) begin
        cmd_err <= 1'b0;
      end else if (byte_done) begin
        if (state == S_RX_ROM) begin
          if (rx_byte != 8'hCC) cmd_err <= 1'b1;
        end else begin
          last_cmd <= rx_byte;
          if (rx_byte == 8'h44) begin
            conv_pulse <= 1'b1;
            sp_temp    <= temp_in;
          end else if (rx_byte != 8'hBE) begin
            cmd_err <= 1'b1;
          end
        end
      end

      if (state != S_TX) begin
        bit_idx <= 7'd0;
        crc     <= 8'h00;
      end else if (fall) begin
        bit_idx <= bit_idx + 7'd1;
        crc     <= bit_idx[6] ? {1'b0, crc[7:1]} : crc_step;
      end

      if (rst_det)                 hold_cnt <= 5'd0;
      else if (tx_fall && !tx_bit) hold_cnt <= HOLD_LOAD;
      else if (hold_cnt != 5'd0)   hold_cnt <= hold_cnt - 5'd1;
    end
  end

endmodule

// File: tb/tb_ow_temp_responder.sv
// Bench for ow_temp_responder: a bit-level 1-Wire master with randomized slot
// timing, checked against a protocol-level model of the responder.
`timescale 1ns/1ps
module tb_ow_temp_responder;
  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        m_low = 1'b0;
  logic [15:0] temp_in = 16'h0000;
  wire         dq;
  logic        conv_pulse, cmd_err, tx_active;
  logic [7:0]  last_cmd;

  assign dq = m_low ? 1'b0 : 1'bz;
  pullup (dq);

  always #5 clk_in = ~clk_in;

  ow_temp_responder dut (
    .clk_in(clk_in), .rst(rst), .dq(dq), .temp_in(temp_in),
    .conv_pulse(conv_pulse), .last_cmd(last_cmd), .cmd_err(cmd_err), .tx_active(tx_active)
  );

  int errors = 0, checks = 0;
  int exp_conv = 0, conv_seen = 0;
  int mode = 0;                 // 0 ignoring, 1 wants ROM, 2 wants function, 3 serving
  int tx_slot = 0;
  logic        steady = 1'b0;
  logic [15:0] sp_model = 16'h0550;
  logic [7:0]  exp_last = 8'h00;
  logic        exp_err = 1'b0, exp_tx = 1'b0;
  logic [7:0]  sp_bytes [9];
  logic [7:0]  rd_bytes [9];
  logic [7:0]  lit_default [9] = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic void build_sp();
    logic [7:0] c, b;
    sp_bytes[0] = sp_model[7:0];
    sp_bytes[1] = sp_model[15:8];
    sp_bytes[2] = 8'h4B; sp_bytes[3] = 8'h46; sp_bytes[4] = 8'h7F;
    sp_bytes[5] = 8'hFF; sp_bytes[6] = 8'h0C; sp_bytes[7] = 8'h10;
    c = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b = sp_bytes[i];
      for (int j = 0; j < 8; j++) begin
        if ((c[0] ^ b[0]) == 1'b1) c = (c >> 1) ^ 8'h8C;
        else                       c = c >> 1;
        b = b >> 1;
      end
    end
    sp_bytes[8] = c;
  endfunction

  always @(negedge clk_in) if (conv_pulse) conv_seen++;

  always @(negedge clk_in) begin
    if (steady && !rst) begin
      check("last_cmd", last_cmd, exp_last);
      check("cmd_err", cmd_err, exp_err);
      check("tx_active", tx_active, exp_tx);
      check("conv_pulse_quiet", conv_pulse, 1'b0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic write_bit(input logic b);
    int lowlen, slot;
    lowlen = b ? $urandom_range(1, 5) : $urandom_range(12, 50);
    slot   = b ? 14 + $urandom_range(0, 4) : lowlen + $urandom_range(3, 6);
    m_low = 1'b1; tick(lowlen);
    m_low = 1'b0; tick(slot - lowlen);
  endtask

  task automatic write_byte(input logic [7:0] b);
    steady = 1'b0;
    for (int i = 0; i < 8; i++) write_bit(b[i]);
    case (mode)
      1: if (b == 8'hCC) mode = 2; else begin exp_err = 1'b1; mode = 0; end
      2: begin
        exp_last = b;
        mode = 0;
        if (b == 8'h44) begin exp_conv++; sp_model = temp_in; end
        else if (b == 8'hBE) begin mode = 3; tx_slot = 0; exp_tx = 1'b1; build_sp(); end
        else exp_err = 1'b1;
      end
      default: ;
    endcase
    steady = 1'b1;
  endtask

  task automatic read_slot(output logic bval);
    int lowlen, slot;
    logic expb, serving;
    serving = (mode == 3);
    expb = serving ? sp_bytes[tx_slot / 8][tx_slot % 8] : 1'b1;
    if (serving && tx_slot == 71) steady = 1'b0;
    lowlen = $urandom_range(1, 2);
    slot   = $urandom_range(34, 38);
    m_low = 1'b1; tick(lowlen);
    m_low = 1'b0; tick(3 - lowlen);
    #4 bval = dq;
    check("read_bit", dq, expb);
    tick(26);
    #4 check("read_hold", dq, expb);
    tick(3);
    #4 check("read_release", dq, 1'b1);
    tick(slot - 32);
    if (serving) begin
      tx_slot++;
      if (tx_slot == 72) begin mode = 0; exp_tx = 1'b0; end
    end
    steady = 1'b1;
  endtask

  task automatic read_bytes(input int nslots);
    logic b;
    for (int s = 0; s < nslots; s++) begin
      read_slot(b);
      rd_bytes[s / 8][s % 8] = b;
    end
  endtask

  task automatic reset_pulse(input int len);
    logic pres;
    pres = (len >= 85);
    steady = 1'b0;
    m_low = 1'b1; tick(len);
    m_low = 1'b0;
    for (int k = 0; k < 70; k++) begin
      #4 check("presence_window", dq, (pres && k >= 4 && k <= 63) ? 1'b0 : 1'b1);
      tick(1);
    end
    if (pres) begin mode = 1; exp_err = 1'b0; exp_tx = 1'b0; tx_slot = 0; end
    steady = 1'b1;
  endtask

  task automatic full_read(input logic do_reset);
    if (do_reset) reset_pulse($urandom_range(85, 120));
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_bytes(72);
    for (int i = 0; i < 9; i++) check("scratchpad_byte", rd_bytes[i], sp_bytes[i]);
  endtask

  task automatic convert(input logic [15:0] t);
    temp_in = t;
    reset_pulse($urandom_range(85, 120));
    write_byte(8'hCC);
    write_byte(8'h44);
    check("conv_pulse_count", conv_seen, exp_conv);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic b;
    logic [15:0] t16;
    logic [7:0] r;
    int op;

    tick(3);
    #4;
    check("reset_dq", dq, 1'b1);
    check("reset_conv_pulse", conv_pulse, 1'b0);
    check("reset_last_cmd", last_cmd, 8'h00);
    check("reset_cmd_err", cmd_err, 1'b0);
    check("reset_tx_active", tx_active, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(2);
    steady = 1'b1;

    // Power-on scratchpad
    reset_pulse(101);
    full_read(1'b0);
    for (int i = 0; i < 9; i++) check("default_byte_literal", rd_bytes[i], lit_default[i]);

    // Short low pulse is ignored; the responder stays silent
    reset_pulse(50);
    write_byte(8'hCC);
    read_slot(b);

    // Convert T with 25 degrees
    convert(16'h0190);
    check("last_cmd_convert", last_cmd, 8'h44);
    temp_in = 16'($urandom);
    full_read(1'b1);
    t16 = {rd_bytes[1], rd_bytes[0]};
    check("temp_word", t16, 16'h0190);
    check("temp_integer", t16[8:4], 5'd25);

    // Abort mid-read, then restart from byte 0
    reset_pulse(101);
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_bytes(9);
    reset_pulse(101);
    full_read(1'b0);

    // Unsupported ROM command, then unsupported function command
    reset_pulse(101);
    write_byte(8'h33);
    check("cmd_err_bad_rom", cmd_err, 1'b1);
    write_byte(8'hCC);
    read_slot(b);
    reset_pulse(101);
    check("cmd_err_cleared", cmd_err, 1'b0);
    write_byte(8'hCC);
    write_byte(8'hA5);
    check("cmd_err_bad_func", cmd_err, 1'b1);
    check("last_cmd_bad_func", last_cmd, 8'hA5);

    for (int it = 0; it < 8; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: convert(16'($urandom));
        1: full_read(1'b1);
        2: begin
          reset_pulse($urandom_range(85, 120));
          write_byte(8'hCC);
          write_byte(8'hBE);
          read_bytes($urandom_range(1, 71));
        end
        3: begin
          reset_pulse($urandom_range(85, 120));
          if ($urandom_range(0, 1) == 0) begin
            do r = 8'($urandom); while (r == 8'hCC);
            write_byte(r);
          end else begin
            do r = 8'($urandom); while (r == 8'h44 || r == 8'hBE);
            write_byte(8'hCC);
            write_byte(r);
          end
          check("cmd_err_random_bad", cmd_err, 1'b1);
        end
        default: begin
          convert(16'($urandom));
          reset_pulse($urandom_range(20, 70));
          read_slot(b);
        end
      endcase
    end

    // Asynchronous reset releases the bus mid-presence and restores defaults
    convert(16'h1234);
    steady = 1'b0;
    m_low = 1'b1; tick(100);
    m_low = 1'b0; tick(10);
    #4 check("presence_before_rst", dq, 1'b0);
    #2 rst = 1'b1;
    #1 check("rst_releases_dq", dq, 1'b1);
    check("rst_last_cmd", last_cmd, 8'h00);
    tick(2);
    rst = 1'b0;
    mode = 0; sp_model = 16'h0550; exp_last = 8'h00; exp_err = 1'b0; exp_tx = 1'b0;
    tick(2);
    steady = 1'b1;
    full_read(1'b1);
    for (int i = 0; i < 9; i++) check("post_rst_byte_literal", rd_bytes[i], lit_default[i]);
    check("conv_pulse_total", conv_seen, exp_conv);

    steady = 1'b0;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
